// File: rtl/l2_cache_sa_pkg.sv
// l2_cache_pkg: shared FSM state type, default parameters and field-width helpers
// for the l2_cache_sa block. No ports.
package l2_cache_pkg;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_WAYS       = 4;
    localparam int DEF_SETS       = 16;
    localparam int DEF_LINE_WORDS = 8;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, ACCESS, RESPOND} state_t;

    // Index width that never collapses to zero bits (a 1-way cache still needs a way field).
    function automatic int bits_for(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return v + {31'd0, ~&v};
    endfunction
endpackage

// File: rtl/l2_cache_sa_if.sv
// l2_cache_if: bundles the L1-side request/response, stall and the 64-bit memory
// burst channel. Modports: master (requester + memory model), slave (the cache).
interface l2_cache_if
    import l2_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  l1_req;
    logic                  l1_we;
    logic [ADDR_WIDTH-1:0] l1_addr;
    logic [31:0]           l1_wdata;
    logic [31:0]           l1_rdata;
    logic                  l1_ack;
    logic                  stall;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [63:0]           mem_wdata;
    logic                  mem_wready;
    logic [63:0]           mem_rdata;
    logic                  mem_rvalid;

    modport master (
        output l1_req, l1_we, l1_addr, l1_wdata, mem_wready, mem_rdata, mem_rvalid,
        input  l1_rdata, l1_ack, stall, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  l1_req, l1_we, l1_addr, l1_wdata, mem_wready, mem_rdata, mem_rvalid,
        output l1_rdata, l1_ack, stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/l2_cache_sa_lru.sv
// l2_lru: age-based LRU for one set. Ports: age/valid of the set, acc (way being
// accessed) in; age_next (ages after touching acc) and victim (lowest invalid way,
// else the oldest) out. Purely combinational.
module l2_lru
    import l2_cache_pkg::*;
#(
    parameter int  WAYS = DEF_WAYS,
    localparam int AB   = bits_for(WAYS)
) (
    input  logic [WAYS*AB-1:0] age,
    input  logic [WAYS-1:0]    valid,
    input  logic [AB-1:0]      acc,
    output logic [WAYS*AB-1:0] age_next,
    output logic [AB-1:0]      victim
);
    logic [AB-1:0] acc_age, oldest;

    assign acc_age = age[int'(acc)*AB +: AB];

    always_comb begin
        age_next = age;
        victim = '0;
        oldest = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (AB'(i) == acc) age_next[i*AB +: AB] = '0;
            else if (age[i*AB +: AB] < acc_age) age_next[i*AB +: AB] = age[i*AB +: AB] + 1'b1;
            if (age[i*AB +: AB] >= oldest) begin
                oldest = age[i*AB +: AB];
                victim = AB'(i);
            end
        end
        // Descending scan so the lowest-index invalid way wins over the oldest.
        for (int i = WAYS - 1; i >= 0; i--)
            if (!valid[i]) victim = AB'(i);
    end
endmodule

// File: rtl/l2_cache_sa.sv
// l2_cache_sa: set-associative write-back/write-allocate L2 with LRU replacement.
// Ports: clk, reset (sync, active-high), bus (l2_cache_if.slave: L1 req/ack, stall,
// 64-bit memory burst channel). Define L2_STATS_EN to add saturating hit_count,
// miss_count and wb_count outputs.
module l2_cache_sa
    import l2_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WAYS       = DEF_WAYS,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    l2_cache_if.slave   bus
`ifdef L2_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count
`endif
);
    localparam int WB    = $clog2(LINE_WORDS);
    localparam int SB    = $clog2(SETS);
    localparam int OB    = WB + 2;
    localparam int TW    = ADDR_WIDTH - OB - SB;
    localparam int AB    = bits_for(WAYS);
    localparam int BEATS = LINE_WORDS / 2;
    localparam int BB    = bits_for(BEATS);

    state_t             state, next;
    logic [ADDR_WIDTH-1:2] addr;
    logic [31:0]        wdata, rdata;
    logic               we, hit, last;
    logic [AB-1:0]      way, hit_way, victim;
    logic [BB-1:0]      beat;
    logic [WB-1:0]      w0, w1;
    logic [SB-1:0]      set;
    logic [TW-1:0]      tag;
    logic [TW-1:0]      tags [SETS][WAYS];
    logic [WAYS-1:0]    valid [SETS];
    logic [WAYS-1:0]    dirty [SETS];
    logic [WAYS*AB-1:0] age [SETS];
    logic [WAYS*AB-1:0] age_next;
    logic [31:0]        data [SETS][WAYS][LINE_WORDS];

    assign set  = addr[OB +: SB];
    assign tag  = addr[ADDR_WIDTH-1 -: TW];
    assign last = beat == BB'(BEATS - 1);
    assign w0   = WB'({beat, 1'b0});
    assign w1   = WB'({beat, 1'b1});

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        for (int i = 0; i < WAYS; i++)
            if (valid[set][i] && tags[set][i] == tag) begin
                hit = 1'b1;
                hit_way = AB'(i);
            end
    end

    // `way` holds the hit/victim way from LOOKUP onward, so it doubles as the LRU access way.
    l2_lru #(.WAYS(WAYS)) u_lru (
        .age(age[set]), .valid(valid[set]), .acc(way), .age_next(age_next), .victim(victim)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE:      next = bus.l1_req ? LOOKUP : IDLE;
            LOOKUP:    next = hit ? ACCESS : dirty[set][victim] ? WRITEBACK : FILL;
            WRITEBACK: next = bus.mem_wready && last ? FILL : WRITEBACK;
            FILL:      next = bus.mem_rvalid && last ? ACCESS : FILL;
            ACCESS:    next = RESPOND;
            default:   next = IDLE;
        endcase
    end

    assign bus.l1_ack    = state == RESPOND;
    assign bus.l1_rdata  = rdata;
    assign bus.stall     = state != IDLE;
    assign bus.mem_req   = state == WRITEBACK || state == FILL;
    assign bus.mem_we    = state == WRITEBACK;
    assign bus.mem_addr  = state == WRITEBACK ? {tags[set][way], set, {OB{1'b0}}}
                         : state == FILL ? {tag, set, {OB{1'b0}}} : '0;
    assign bus.mem_wdata = state == WRITEBACK ? {data[set][way][w1], data[set][way][w0]} : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            beat <= '0;
            way <= '0;
            rdata <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int i = 0; i < WAYS; i++) age[s][i*AB +: AB] <= AB'(i);
            end
        end else begin
            state <= next;
            if (state == LOOKUP) way <= hit ? hit_way : victim;
            if ((state == WRITEBACK && bus.mem_wready) || (state == FILL && bus.mem_rvalid))
                beat <= last ? '0 : beat + 1'b1;
            // Valid only on the final beat: a reset mid-fill leaves the partial line invalid.
            if (state == FILL && bus.mem_rvalid && last) begin
                valid[set][way] <= 1'b1;
                dirty[set][way] <= 1'b0;
            end
            if (state == ACCESS) begin
                age[set] <= age_next;
                if (we) dirty[set][way] <= 1'b1;
                else rdata <= data[set][way][addr[2 +: WB]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.l1_req) begin
            addr <= bus.l1_addr[ADDR_WIDTH-1:2];
            wdata <= bus.l1_wdata;
            we <= bus.l1_we;
        end
        if (state == FILL && bus.mem_rvalid) begin
            data[set][way][w0] <= bus.mem_rdata[31:0];
            data[set][way][w1] <= bus.mem_rdata[63:32];
            if (last) tags[set][way] <= tag;
        end
        if (state == ACCESS && we) data[set][way][addr[2 +: WB]] <= wdata;
    end

`ifdef L2_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count <= '0;
            miss_count <= '0;
            wb_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit) hit_count <= sat_inc(hit_count);
            else miss_count <= sat_inc(miss_count);
            if (!hit && dirty[set][victim]) wb_count <= sat_inc(wb_count);
        end
    end
`endif
endmodule

// File: tb/tb_l2_cache_sa.sv
// tb_l2_cache_sa: scoreboard bench for l2_cache_sa with a gap-programmable burst
// memory model; stats ports are checked only when L2_STATS_EN is defined.
module tb_l2_cache_sa;
    typedef struct {
        logic        we;
        logic [31:0] data;
        bit          hit;
        int          t0;
        int          m0;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0, checks = 0, cyc = 0, acks = 0;
    int   gap = 0, mreq_cycles = 0, fill_beats = 0, wb_beats = 0;
    logic [31:0] last_fill_addr = '0, last_wb_addr = '0;
    logic [63:0] wb_beat0 = '0;
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    exp_t  exp_q [$];
    string tag_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l2_cache_if #(.ADDR_WIDTH(32)) bus ();
`ifdef L2_STATS_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    // 8 sets so that 0x100, 0x200, 0x400, 0x600 and 0x800 all land in set 0.
    l2_cache_sa #(.ADDR_WIDTH(32), .WAYS(4), .SETS(8), .LINE_WORDS(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef L2_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count),
        .wb_count(wb_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Backing memory content before any write-back: line base bits plus word index.
    function automatic logic [31:0] word_val(input logic [31:0] a);
        return (a & 32'hFFFF_FE00) | ((a >> 2) & 32'd7);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : word_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : word_val(a);
    endfunction

    // Memory model: acts at posedge+2, presents one beat after `gap` idle cycles.
    initial begin : mem_model
        int beat;
        int gcnt;
        logic prev_we;
        logic [31:0] ba;
        beat = 0;
        gcnt = 0;
        prev_we = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_wready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_rvalid = 1'b0;
            bus.mem_wready = 1'b0;
            if (!bus.mem_req || bus.mem_we != prev_we) begin
                beat = 0;
                gcnt = 0;
            end
            prev_we = bus.mem_we;
            if (bus.mem_req) begin
                mreq_cycles++;
                if (gcnt < gap) gcnt++;
                else begin
                    gcnt = 0;
                    ba = bus.mem_addr + 32'(8 * beat);
                    if (bus.mem_we) begin
                        if (beat == 0) begin
                            wb_beat0 = bus.mem_wdata;
                            last_wb_addr = bus.mem_addr;
                        end
                        mem_store[ba] = bus.mem_wdata[31:0];
                        mem_store[ba + 4] = bus.mem_wdata[63:32];
                        wb_beats++;
                        bus.mem_wready = 1'b1;
                    end else begin
                        if (beat == 0) last_fill_addr = bus.mem_addr;
                        bus.mem_rdata = {mem_rd(ba + 4), mem_rd(ba)};
                        fill_beats++;
                        bus.mem_rvalid = 1'b1;
                    end
                    beat++;
                end
            end
        end
    end

    // Scoreboard: pops one expectation per l1_ack.
    initial begin : monitor
        exp_t e;
        string t;
        forever begin
            @(negedge clk);
            if (bus.l1_ack) begin
                acks++;
                check("ack_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    if (!e.we) check({t, "_rdata"}, bus.l1_rdata, e.data);
                    if (e.hit) begin
                        check({t, "_hit_lat"}, 64'(cyc - e.t0), 3);
                        check({t, "_hit_nomem"}, 64'(mreq_cycles - e.m0), 0);
                    end else check({t, "_miss_mem"}, 64'(mreq_cycles > e.m0), 1);
                end
            end
        end
    end

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit exp_hit, input string tag);
        exp_t e;
        bit got;
        @(negedge clk);
        bus.l1_req = 1'b1;
        bus.l1_we = w;
        bus.l1_addr = a;
        bus.l1_wdata = d;
        e.we = w;
        e.data = w ? d : ref_rd(a);
        e.hit = exp_hit;
        e.t0 = cyc;
        e.m0 = mreq_cycles;
        if (w) ref_mem[a] = d;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = bus.l1_ack;
        end
        if (!got) check({tag, "_timeout"}, 0, 1);
        bus.l1_req = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int fb0, wb0, n0;
        bus.l1_req = 1'b0;
        bus.l1_we = 1'b0;
        bus.l1_addr = '0;
        bus.l1_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ack", bus.l1_ack, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_rdata", bus.l1_rdata, 0);
`ifdef L2_STATS_EN
        check("rst_counts", {hit_count, miss_count | wb_count}, 0);
`endif
        fb0 = fill_beats;
        access(1'b0, 32'h104, 0, 1'b0, "rd104_miss");
        check("fill1_addr", last_fill_addr, 32'h100);
        check("fill1_beats", 64'(fill_beats - fb0), 4);
`ifdef L2_STATS_EN
        check("miss_count1", miss_count, 1);
`endif
        access(1'b0, 32'h104, 0, 1'b1, "rd104_hit");
`ifdef L2_STATS_EN
        check("hit_count1", hit_count, 1);
`endif
        access(1'b1, 32'h104, 32'hDEADBEEF, 1'b1, "wr104");
        access(1'b0, 32'h200, 0, 1'b0, "rd200");
        access(1'b0, 32'h400, 0, 1'b0, "rd400");
        access(1'b0, 32'h600, 0, 1'b0, "rd600");
        wb0 = wb_beats;
        access(1'b0, 32'h800, 0, 1'b0, "rd800");
        check("wb_addr", last_wb_addr, 32'h100);
        check("wb_beat0", wb_beat0, 64'hDEADBEEF_00000000);
        check("wb_beats", 64'(wb_beats - wb0), 4);
        check("fill800_addr", last_fill_addr, 32'h800);
`ifdef L2_STATS_EN
        check("wb_count1", wb_count, 1);
`endif
        access(1'b0, 32'h104, 0, 1'b0, "rd104_after_wb");
        gap = 3;
        fb0 = fill_beats;
        access(1'b0, 32'hA1C, 0, 1'b0, "gap_miss");
        check("gap_fill_beats", 64'(fill_beats - fb0), 4);
        gap = 0;
        for (int i = 0; i < 7; i++) access(1'b0, 32'hA00 + 32'(4 * i), 0, 1'b1, "gap_word");
        @(negedge clk);
        bus.l1_req = 1'b1;
        bus.l1_we = 1'b0;
        bus.l1_addr = 32'hC04;
        fb0 = fill_beats;
        for (int i = 0; i < 100 && fill_beats < fb0 + 3; i++) @(negedge clk);
        check("rst_beat2_reached", 64'(fill_beats - fb0), 3);
        reset = 1'b1;
        bus.l1_req = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_req", bus.mem_req, 0);
        check("rst_mid_ack", bus.l1_ack, 0);
        reset = 1'b0;
        n0 = acks;
        repeat (10) @(negedge clk);
        check("rst_mid_no_ack", 64'(acks - n0), 0);
`ifdef L2_STATS_EN
        check("rst_mid_counts", {hit_count, miss_count | wb_count}, 0);
`endif
        access(1'b0, 32'hC04, 0, 1'b0, "rdC04_after_rst");
`ifdef L2_STATS_EN
        check("miss_count_final", miss_count, 1);
`endif
        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l2_cache_sa.md
L2_CACHE_SA -- requirements
Module: l2_cache_sa

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameter WAYS, default 4, associativity; legal values 1, 2, 4, 8.
REQ-003 Parameter SETS, default 16, set count; power of two, at least 2.
REQ-004 Parameter LINE_WORDS, default 8, 32-bit words per line; even power of two; burst length = LINE_WORDS/2 beats.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 l1_req  in  1  access request; held with address and data until l1_ack.
REQ-008 l1_we  in  1  1 = write, 0 = read.
REQ-009 l1_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
REQ-010 l1_wdata  in  32  write data.
REQ-011 l1_rdata  out  32  read data; valid in the l1_ack cycle.
REQ-012 l1_ack  out  1  one-cycle completion pulse.
REQ-013 stall  out  1  high whenever the FSM is not IDLE.
REQ-014 mem_req  out  1  burst request; held until the last beat completes.
REQ-015 mem_we  out  1  1 = write-back burst, 0 = fill burst.
REQ-016 mem_addr  out  ADDR_WIDTH  line-aligned burst address.
REQ-017 mem_wdata  out  64  write-back beat as {word 2k+1, word 2k}.
REQ-018 mem_wready  in  1  write beat accepted this cycle.
REQ-019 mem_rdata  in  64  fill beat as {word 2k+1, word 2k}.
REQ-020 mem_rvalid  in  1  fill beat valid this cycle.

Function
REQ-021 Address fields: word = [log2(LINE_WORDS)+1:2]; set = next log2(SETS) bits; tag = the remaining upper bits.
REQ-022 FSM states: IDLE, LOOKUP, WRITEBACK, FILL, ACCESS, RESPOND.
REQ-023 IDLE: on l1_req, capture address, write data and we, then go to LOOKUP.
REQ-024 LOOKUP: a valid way with a matching tag is a hit and goes to ACCESS; otherwise the access is a miss.
REQ-025 Hit latency: l1_ack asserts exactly 3 cycles after the cycle in which l1_req is sampled in IDLE.
REQ-026 Victim selection: the lowest-index invalid way; otherwise the LRU way.
REQ-027 A miss with a dirty victim goes to WRITEBACK; any other miss goes to FILL.
REQ-028 WRITEBACK: mem_we=1; mem_addr={victim tag, set, 0}; beat k is presented until mem_wready; after LINE_WORDS/2 accepted beats, go to FILL.
REQ-029 FILL: mem_we=0; mem_addr is the line-aligned request address; each mem_rvalid beat writes two words; after the last beat, set the tag, valid=1 and dirty=0, then go to ACCESS.
REQ-030 mem_rvalid and mem_wready SHALL be ignored while mem_req is low; gaps between beats of any length SHALL be tolerated.
REQ-031 ACCESS: a read loads l1_rdata; a write stores l1_wdata and sets dirty; the LRU state is updated; then go to RESPOND.
REQ-032 RESPOND: l1_ack=1 for one cycle, then go to IDLE; a new request is not accepted in the ack cycle.
REQ-033 LRU: per-set age of log2(WAYS) bits per way; the accessed way gets age 0; each way younger than the accessed way increments; the victim is the way with maximum age.

Reset
REQ-034 Reset SHALL force IDLE and set l1_ack, stall, mem_req, mem_we=0 and mem_addr, mem_wdata, l1_rdata=0.
REQ-035 Reset SHALL clear all valid and dirty bits and set each way's age equal to its index; the data array is not reset.
REQ-036 Reset mid-burst SHALL drop mem_req in the next cycle, produce no l1_ack, and discard the partial line.

Configuration
REQ-037 With L2_STATS_EN defined: add outputs hit_count, miss_count and wb_count, each 32 bits, each saturating at all-ones and cleared by reset.
REQ-038 With L2_STATS_EN undefined: these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-039 Package l2_cache_pkg SHALL hold the FSM state enum, the default parameter values and the log2 field-width constants/functions.
REQ-040 Sub-module l2_lru SHALL implement the per-set age update and victim select; it is instantiated once, combinationally, for the addressed set.

Verification
REQ-041 After reset, read 0x104; fill beats {2k+1, 2k} -> miss, 4 fill beats at 0x100, l1_rdata=1, miss_count=1.
REQ-042 Read 0x104 again -> l1_ack 3 cycles after request, l1_rdata=1, mem_req never asserted, hit_count=1.
REQ-043 Write 0xDEADBEEF to 0x104, then read 0x200, 0x400, 0x600, 0x800 -> the 0x800 miss writes back 0x100, beat0=0xDEADBEEF_00000000, wb_count=1, then fills 0x800.
REQ-044 Fill with 3 idle cycles between every mem_rvalid beat -> all 8 words correct, single l1_ack.
REQ-045 Assert reset during fill beat 2 -> mem_req=0 next cycle, no l1_ack; a later read of the same address misses.
REQ-046 Build without L2_STATS_EN -> bench compiles without counter ports and scenarios REQ-041 to REQ-045 pass unchanged.
